// File: rtl/decoder128_stream.sv
// Registered 7-to-128 one-hot decoder with valid/ready flow control.
// A two-entry skid buffer (OREG + SREG) sustains full throughput under back-pressure.
module decoder128_stream #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     dataout,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Encodes (OREG.valid, SREG.valid); (0,1) has no state of its own.
    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [6:0]       ocode_q, ocode_d;
    logic [6:0]       scode_q, scode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic xfer;

    // Both handshakes depend only on registered state.
    assign out_valid = (state_q != StEmpty);
    assign in_ready  = (state_q != StFull);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        ocode_d = ocode_q;
        scode_d = scode_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    state_d = StOne;
                    ocode_d = datain;
                end
            end
            StOne: begin
                if (accept && xfer) begin
                    ocode_d = datain;
                end else if (accept) begin
                    state_d = StFull;
                    scode_d = datain;
                end else if (xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (xfer) begin
                    state_d = StOne;
                    ocode_d = scode_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            ocode_q <= 7'd0;
            scode_q <= 7'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ocode_q <= ocode_d;
            scode_q <= scode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dataout  = out_valid ? (128'(1) << ocode_q) : 128'h0;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_decoder128_stream.sv
// Scoreboard bench for decoder128_stream: the driver queues accepted codes,
// the monitor pops and compares on every output transfer.
module tb_decoder128_stream;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [6:0]   datain = 7'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] dataout;
    logic [7:0]   xfer_cnt;

    int           n_checks = 0;
    int           n_fail = 0;
    logic [6:0]   exp_q[$];
    logic [7:0]   exp_cnt = 8'd0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = 128'h0;

    decoder128_stream #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; acc reports whether the code was taken.
    task automatic cycle(input logic iv, input logic [6:0] code, input logic ordy,
                         output logic acc);
        in_valid  = iv;
        datain    = code;
        out_ready = ordy;
        @(negedge clk);
        acc = iv && in_ready;
        if (acc) exp_q.push_back(code);
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every cycle away from the active edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 128'(out_valid), 128'd1);
                check("stall_data", dataout, prev_data);
            end
            if (out_valid) begin
                check("popcount", 128'($countones(dataout)), 128'd1);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out: got %h expected no output", dataout);
                    end else begin
                        logic [6:0] code;
                        code = exp_q.pop_front();
                        check("dataout", dataout, 128'(1) << code);
                    end
                    check("xfer_cnt", 128'(xfer_cnt), 128'(exp_cnt));
                    exp_cnt = exp_cnt + 8'd1;
                end
            end else begin
                check("idle_dataout", dataout, 128'h0);
                check("illegal_state", 128'(in_ready), 128'd1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = dataout;
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        exp_cnt = 8'd0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic acc;
        logic pend;
        logic iv;
        logic ordy;
        logic [6:0] code;

        // Reset then single word
        do_reset(2);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_dataout", dataout, 128'h0);
        check("rst_xfer_cnt", 128'(xfer_cnt), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        cycle(1'b1, 7'd0, 1'b1, acc);
        check("single_valid", 128'(out_valid), 128'd1);
        check("single_data", dataout, 128'h1);
        cycle(1'b0, 7'd0, 1'b1, acc);
        check("single_cnt", 128'(xfer_cnt), 128'd1);
        check("single_gone", 128'(out_valid), 128'd0);

        // Two back-to-back sweeps of all 128 codes: counter wraps to 0
        do_reset(1);
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 128; n++) begin
                cycle(1'b1, 7'(n), 1'b1, acc);
                check("sweep_valid", 128'(out_valid), 128'd1);
                if (n == 12 || n == 60 || n == 124)
                    check("sweep_bit", dataout, 128'(1) << n);
            end
        end
        cycle(1'b0, 7'd0, 1'b1, acc);
        check("sweep_wrap_cnt", 128'(xfer_cnt), 128'd0);

        // Back-pressure: 5 and 6 absorbed, 7 held off
        cycle(1'b1, 7'd5, 1'b0, acc);
        cycle(1'b1, 7'd6, 1'b0, acc);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_data", dataout, 128'h20);
        cycle(1'b1, 7'd7, 1'b0, acc);
        check("bp_held", 128'(acc), 128'd0);
        check("bp_data2", dataout, 128'h20);
        cycle(1'b1, 7'd7, 1'b1, acc);
        check("bp_out6", dataout, 128'h40);
        cycle(1'b1, 7'd7, 1'b1, acc);
        check("bp_out7", dataout, 128'h80);
        cycle(1'b0, 7'd0, 1'b1, acc);
        check("bp_drain", 128'(exp_q.size()), 128'd0);

        // Alternating 127/64 in ONE: no bubble, in_ready stays high
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 7'd127 : 7'd64, 1'b1, acc);
            check("alt_in_ready", 128'(in_ready), 128'd1);
            check("alt_data", dataout, (i % 2 == 0) ? (128'h1 << 127) : (128'h1 << 64));
        end
        cycle(1'b0, 7'd0, 1'b1, acc);

        // Random stall; a refused offer is held until it is taken
        pend = 1'b0;
        iv = 1'b0;
        code = 7'd0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend) begin
                iv   = 1'($urandom_range(0, 1));
                code = 7'($urandom_range(0, 127));
            end
            ordy = 1'($urandom_range(0, 1));
            cycle(iv, code, ordy, acc);
            pend = iv && !acc;
        end
        repeat (4) cycle(1'b0, 7'd0, 1'b1, acc);
        check("rand_drain", 128'(exp_q.size()), 128'd0);

        // Reset while FULL discards both words
        cycle(1'b1, 7'd9, 1'b0, acc);
        cycle(1'b1, 7'd10, 1'b0, acc);
        check("full_in_ready", 128'(in_ready), 128'd0);
        do_reset(1);
        check("mid_out_valid", 128'(out_valid), 128'd0);
        check("mid_dataout", dataout, 128'h0);
        check("mid_xfer_cnt", 128'(xfer_cnt), 128'd0);
        check("mid_in_ready", 128'(in_ready), 128'd1);
        repeat (3) cycle(1'b0, 7'd0, 1'b1, acc);
        check("mid_no_out", 128'(out_valid), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder128_stream.md
# decoder128_stream

Registered 7-bit-to-128-bit one-hot decoder with valid/ready flow control on both sides. It converts a binary index `datain` into a one-hot word `dataout` with bit `datain` set. It sits on the transmit side of the 128-line one-hot select path, mirroring the 128-to-7 encoder on the receive side. A two-entry skid buffer gives full throughput under back-pressure, and a transfer counter supports loopback checking.

## Interface
- `CNT_W`, default 8: width of the accepted-transfer counter; the counter wraps modulo 2^CNT_W.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high; takes effect on the rising edge of `clk` while high.
- `in_valid`, input, 1: upstream has a code on `datain`.
- `in_ready`, output, 1: block can accept a code this cycle.
- `datain`, input, 7: binary index 0..127.
- `out_valid`, output, 1: `dataout` holds a decoded word.
- `out_ready`, input, 1: downstream consumes `dataout` this cycle.
- `dataout`, output, 128: one-hot word, `dataout[datain_accepted] = 1`.
- `xfer_cnt`, output, CNT_W: number of output transfers completed (`out_valid && out_ready`), modulo 2^CNT_W.

## Operation
- **Storage**
  - Output register: OREG (valid bit + 7-bit code).
  - Skid register: SREG (valid bit + 7-bit code).
  - Only the 7-bit code is stored. `dataout` is decoded from OREG's code and gated by OREG valid.
- **Decode rule**
  - Exact for every index: code n sets bit n only, n = 0..127, no exceptions.
  - `dataout` = 128'h0 whenever `out_valid` = 0.
- **Handshakes**
  - `in_ready` = !SREG.valid, taken from registered state only; no combinational path from `out_ready`.
  - Input accepted on an edge where `in_valid && in_ready`.
  - Output transfer on an edge where `out_valid && out_ready`.
- **State machine**, states derived from (OREG.valid, SREG.valid):
  - **EMPTY (0,0)**
    - Accept → ONE; OREG loads `datain`.
  - **ONE (1,0)**
    - Accept with transfer → stay ONE; OREG loads `datain`.
    - Accept without transfer → FULL; SREG loads `datain`.
    - Transfer without accept → EMPTY.
  - **FULL (1,1)**, `in_ready` = 0
    - Transfer → ONE; OREG loads SREG.code and SREG clears.
  - (0,1) is illegal and unreachable.
- **Ordering:** strict FIFO; codes leave in the order accepted.
- **Counter:** `xfer_cnt` increments by 1 on every output transfer and wraps from 2^CNT_W−1 to 0.
- **Input conditions**
  - `datain` is ignored when `in_valid` = 0 or `in_ready` = 0.
  - Upstream must hold `datain` stable while `in_valid && !in_ready`.
  - `in_valid` must not drop before acceptance; the block does not check this.

## Timing
- **Reset values**
  - `out_valid` = 0, `dataout` = 0, `xfer_cnt` = 0, SREG.valid = 0.
  - `in_ready` reads 1 in the first cycle after reset.
- **Reset mid-operation:** reset discards OREG and SREG contents (no output transfer counted) and ignores `in_valid`/`out_ready` on that edge.
- **Latency:** a code accepted at edge k appears on `dataout` with `out_valid` = 1 in cycle k+1, when OREG was empty or transferring at edge k.
- **Throughput:** one word per cycle sustained while `out_ready` = 1.
- **Back-pressure:** with `out_ready` = 0 the block absorbs at most 2 words; `in_ready` falls in the cycle after the second accept.
- **Simultaneous events**
  - Accept and transfer in the same cycle: both take effect.
  - In ONE, OREG is replaced with no bubble.
- **Output stability:** `out_valid`/`dataout` are stable while `out_valid && !out_ready`.

## Test plan
- **Reset then single word:** reset 2 cycles; send `datain`=0, `out_ready`=1 → next cycle `dataout`=128'h1 and `out_valid`=1 for one cycle, `xfer_cnt`=1.
- **Full sweep:** stream codes 0..127 back-to-back with `out_ready`=1.
  - Expect 128 consecutive words, `dataout`=1<<n, each exactly one-hot (popcount 1), including n=12, 28, 44, 60, 76, 92, 108, 124.
  - `xfer_cnt` wraps back to 0 at CNT_W=8 after 256 words on a repeated sweep.
- **Back-pressure:** `out_ready`=0; offer codes 5, 6, 7.
  - 5 in OREG (`dataout`=128'h20), 6 in SREG, `in_ready`=0, 7 held.
  - Raise `out_ready` → outputs 5, 6, 7 on consecutive cycles in order; no loss or duplication.
- **Simultaneous accept/transfer in ONE:** alternate codes 127 and 64 each cycle with `out_ready`=1.
  - `dataout` alternates between bit 127 and bit 64 with no idle cycle.
  - `in_ready` stays 1.
- **Random stall:** random `in_valid`/`out_ready` for 10k cycles against a scoreboard queue.
  - Every output equals 1<<expected code.
  - `dataout`=0 whenever `out_valid`=0.
  - State (0,1) is never reached.
- **Reset mid-operation:** assert reset while in FULL.
  - Next cycle: `out_valid`=0, `dataout`=0, `xfer_cnt`=0, `in_ready`=1.
  - The queued codes never appear.
